// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_out_hi;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, alu_out_hi, carry, zero, div_by_zero
  );
  modport slave (
    input  in_valid, a, b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, alu_out_hi, carry, zero, div_by_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked 16-op ALU: single-cycle ops finish at accept, MUL/DIV iterate one bit per cycle.
// q/acc double as the iteration registers and the result registers ({hi,lo}).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] q, acc, b_r;
  logic [3:0]       sel_r;
  logic [CW-1:0]    cnt;
  logic             cf, zf, dbz;

  logic accept, last, iter_op, div0;
  assign accept  = bus.in_valid && (state == IDLE);
  assign last    = (cnt == CW'(WIDTH - 1));
  assign iter_op = (bus.alu_sel == OP_MUL) || (bus.alu_sel == OP_DIV);
  assign div0    = (bus.alu_sel == OP_DIV) && (bus.b == '0);

  // single-cycle result, computed straight from the incoming operands
  logic [WIDTH-1:0] sc_out;
  logic             sc_c;
  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    case (bus.alu_sel)
      4'd0:  {sc_c, sc_out} = {1'b0, bus.a} + {1'b0, bus.b};
      4'd1:  begin sc_out = bus.a - bus.b; sc_c = (bus.a < bus.b); end
      4'd4:  begin sc_out = bus.a << 1; sc_c = bus.a[WIDTH-1]; end
      4'd5:  begin sc_out = bus.a >> 1; sc_c = bus.a[0]; end
      4'd6:  sc_out = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
      4'd7:  sc_out = {bus.a[0], bus.a[WIDTH-1:1]};
      4'd8:  sc_out = bus.a & bus.b;
      4'd9:  sc_out = bus.a | bus.b;
      4'd10: sc_out = bus.a ^ bus.b;
      4'd11: sc_out = ~(bus.a & bus.b);
      4'd12: sc_out = ~(bus.a | bus.b);
      4'd13: sc_out = ~(bus.a ^ bus.b);
      4'd14: sc_out = {{(WIDTH-1){1'b0}}, bus.a > bus.b};
      4'd15: sc_out = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      default: ;
    endcase
  end

  // MUL: add multiplicand into hi when lsb set, then shift {carry,hi,lo} right
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic             div_ge;
  logic [WIDTH-1:0] step_q, step_acc;
  always_comb begin
    mul_sum = {1'b0, acc} + (q[0] ? {1'b0, b_r} : '0);
    div_rs  = {acc, q[WIDTH-1]};
    div_ge  = (div_rs >= {1'b0, b_r});
    if (sel_r == OP_MUL) begin
      step_acc = mul_sum[WIDTH:1];
      step_q   = {mul_sum[0], q[WIDTH-1:1]};
    end else begin
      // restoring divide: partial remainder < b always fits in WIDTH bits
      step_acc = div_ge ? (div_rs[WIDTH-1:0] - b_r) : div_rs[WIDTH-1:0];
      step_q   = {q[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (iter_op && !div0) ? BUSY : DONE;
      BUSY: if (last) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state == IDLE);
    bus.out_valid   = (state == DONE);
    bus.alu_out     = q;
    bus.alu_out_hi  = acc;
    bus.carry       = cf;
    bus.zero        = zf;
    bus.div_by_zero = dbz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0; acc <= '0; b_r <= '0; sel_r <= '0; cnt <= '0;
      cf <= 1'b0; zf <= 1'b0; dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          b_r   <= bus.b;
          sel_r <= bus.alu_sel;
          cnt   <= '0;
          dbz   <= 1'b0;
          acc   <= '0;
          if (div0) begin
            q <= '1; acc <= bus.a; dbz <= 1'b1; cf <= 1'b0; zf <= 1'b0;
          end else if (iter_op) begin
            q <= bus.a;
          end else begin
            q <= sc_out; cf <= sc_c; zf <= (sc_out == '0);
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          q   <= step_q;
          acc <= step_acc;
          if (last) begin
            cf <= (sel_r == OP_MUL) && (step_acc != '0);
            zf <= (step_q == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16 with hand-computed expectations.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8();
  alu_seq_if #(.WIDTH(16)) b16();
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  int tests = 0;
  int fails = 0;

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        output int lat);
    @(negedge clk);
    b8.a = a; b8.b = b; b8.alu_sel = sel; b8.in_valid = 1'b1;
    @(posedge clk); #1 b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 64) begin @(posedge clk); #1 lat++; end
    tests++;
    if (b8.out_valid !== 1'b1) begin fails++; $display("FAIL timeout8 sel=%0d got out_valid=%b want 1", sel, b8.out_valid); end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                         output int lat);
    @(negedge clk);
    b16.a = a; b16.b = b; b16.alu_sel = sel; b16.in_valid = 1'b1;
    @(posedge clk); #1 b16.in_valid = 1'b0;
    lat = 1;
    while (!b16.out_valid && lat < 64) begin @(posedge clk); #1 lat++; end
    tests++;
    if (b16.out_valid !== 1'b1) begin fails++; $display("FAIL timeout16 sel=%0d got out_valid=%b want 1", sel, b16.out_valid); end
  endtask

  task automatic drain8();
    @(negedge clk) b8.out_ready = 1'b1;
    @(posedge clk); #1 b8.out_ready = 1'b0;
  endtask

  task automatic drain16();
    @(negedge clk) b16.out_ready = 1'b1;
    @(posedge clk); #1 b16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({b8.out_valid, b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero} !== 20'h0) begin
      fails++; $display("FAIL reset_outs got %h want 0",
        {b8.out_valid, b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({b8.in_ready, b16.in_ready, b16.out_valid} !== 3'b110) begin
      fails++; $display("FAIL reset_ready got %b want 110", {b8.in_ready, b16.in_ready, b16.out_valid});
    end
  endtask

  // {alu_out, alu_out_hi, carry, zero, div_by_zero}
  task automatic test_basic();
    logic [18:0] exp_r [4];
    int          exp_l [4];
    int lat;
    exp_r = '{{8'd12, 8'd0, 3'b000}, {8'd8, 8'd0, 3'b000}, {8'd20, 8'd0, 3'b000}, {8'd5, 8'd0, 3'b000}};
    exp_l = '{1, 1, 9, 9};
    for (int i = 0; i < 4; i++) begin
      issue8(8'h0A, 8'h02, 4'(i), lat);
      tests++;
      if ({b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero} !== exp_r[i]) begin
        fails++; $display("FAIL basic sel=%0d got %h want %h", i,
          {b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero}, exp_r[i]);
      end
      tests++;
      if (lat != exp_l[i]) begin fails++; $display("FAIL basic_lat sel=%0d got %0d want %0d", i, lat, exp_l[i]); end
      drain8();
    end
  endtask

  task automatic test_flags();
    logic [18:0] exp_r [4];
    int lat;
    exp_r = '{{8'h00, 8'h00, 3'b110}, {8'hEC, 8'h00, 3'b000}, {8'h9C, 8'h09, 3'b100}, {8'd24, 8'd6, 3'b000}};
    for (int i = 0; i < 4; i++) begin
      issue8(8'hF6, 8'h0A, 4'(i), lat);
      tests++;
      if ({b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero} !== exp_r[i]) begin
        fails++; $display("FAIL flags sel=%0d got %h want %h", i,
          {b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero}, exp_r[i]);
      end
      drain8();
    end
  endtask

  // {a, b, sel, expected out, expected carry}
  task automatic test_logic();
    logic [28:0] vec [12];
    int lat;
    vec = '{{8'h81, 8'h00, 4'd4,  8'h02, 1'b1}, {8'h81, 8'h00, 4'd5,  8'h40, 1'b1},
            {8'h81, 8'h00, 4'd6,  8'h03, 1'b0}, {8'h81, 8'h00, 4'd7,  8'hC0, 1'b0},
            {8'hF0, 8'h3C, 4'd8,  8'h30, 1'b0}, {8'hF0, 8'h3C, 4'd9,  8'hFC, 1'b0},
            {8'hF0, 8'h3C, 4'd10, 8'hCC, 1'b0}, {8'hF0, 8'h3C, 4'd11, 8'hCF, 1'b0},
            {8'hF0, 8'h3C, 4'd12, 8'h03, 1'b0}, {8'hF0, 8'h3C, 4'd13, 8'h33, 1'b0},
            {8'h05, 8'h03, 4'd14, 8'h01, 1'b0}, {8'h07, 8'h07, 4'd15, 8'h01, 1'b0}};
    for (int i = 0; i < 12; i++) begin
      issue8(vec[i][28:21], vec[i][20:13], vec[i][12:9], lat);
      tests++;
      if ({b8.alu_out, b8.alu_out_hi, b8.carry} !== {vec[i][8:1], 8'h00, vec[i][0]}) begin
        fails++; $display("FAIL logic sel=%0d got %h want %h", vec[i][12:9],
          {b8.alu_out, b8.alu_out_hi, b8.carry}, {vec[i][8:1], 8'h00, vec[i][0]});
      end
      drain8();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue8(8'h37, 8'h00, 4'd3, lat);
    tests++;
    if ({b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero} !== {8'hFF, 8'h37, 3'b001}) begin
      fails++; $display("FAIL div0 got %h want %h",
        {b8.alu_out, b8.alu_out_hi, b8.carry, b8.zero, b8.div_by_zero}, {8'hFF, 8'h37, 3'b001});
    end
    tests++;
    if (lat != 1) begin fails++; $display("FAIL div0_lat got %0d want 1", lat); end
    drain8();
    issue8(8'h09, 8'h02, 4'd3, lat);
    tests++;
    if ({b8.alu_out, b8.alu_out_hi, b8.div_by_zero} !== {8'd4, 8'd1, 1'b0}) begin
      fails++; $display("FAIL div_after0 got %h want %h", {b8.alu_out, b8.alu_out_hi, b8.div_by_zero}, {8'd4, 8'd1, 1'b0});
    end
    drain8();
  endtask

  task automatic test_backpressure();
    int lat;
    issue8(8'h0A, 8'h02, 4'd0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b8.in_valid = 1'b1; b8.a = 8'h01; b8.b = 8'h01; b8.alu_sel = 4'd1;
      @(posedge clk); #1;
      tests++;
      if ({b8.out_valid, b8.in_ready, b8.alu_out, b8.carry} !== {2'b10, 8'd12, 1'b0}) begin
        fails++; $display("FAIL bp_hold cyc=%0d got %h want %h", i,
          {b8.out_valid, b8.in_ready, b8.alu_out, b8.carry}, {2'b10, 8'd12, 1'b0});
      end
    end
    @(negedge clk) b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    @(posedge clk); #1 b8.out_ready = 1'b0;
    tests++;
    if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_release got %b want 01", {b8.out_valid, b8.in_ready});
    end
    repeat (3) @(posedge clk);
    #1 tests++;
    if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_noqueue got %b want 01", {b8.out_valid, b8.in_ready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen = 0;
    @(negedge clk);
    b8.a = 8'hF6; b8.b = 8'h0A; b8.alu_sel = 4'd2; b8.in_valid = 1'b1;
    @(posedge clk); #1 b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 tests++;
    if ({b8.out_valid, b8.alu_out, b8.alu_out_hi} !== 17'h0) begin
      fails++; $display("FAIL rst_mid got %h want 0", {b8.out_valid, b8.alu_out, b8.alu_out_hi});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1 if (b8.out_valid) seen = 1; end
    tests++;
    if (seen) begin fails++; $display("FAIL rst_mid_noresult got out_valid=1 want 0"); end
    issue8(8'd3, 8'd4, 4'd2, lat);
    tests++;
    if ({b8.alu_out, b8.alu_out_hi, b8.carry} !== {8'd12, 8'd0, 1'b0}) begin
      fails++; $display("FAIL rst_mid_next got %h want %h", {b8.alu_out, b8.alu_out_hi, b8.carry}, {8'd12, 8'd0, 1'b0});
    end
    drain8();
  endtask

  task automatic test_wide();
    int lat;
    issue16(16'hFFFF, 16'hFFFF, 4'd2, lat);
    tests++;
    if ({b16.alu_out, b16.alu_out_hi, b16.carry, b16.zero, b16.div_by_zero} !== {16'h0001, 16'hFFFE, 3'b100}) begin
      fails++; $display("FAIL wide_mul got %h want %h",
        {b16.alu_out, b16.alu_out_hi, b16.carry, b16.zero, b16.div_by_zero}, {16'h0001, 16'hFFFE, 3'b100});
    end
    tests++;
    if (lat != 17) begin fails++; $display("FAIL wide_mul_lat got %0d want 17", lat); end
    drain16();
    issue16(16'h8001, 16'h0000, 4'd4, lat);
    tests++;
    if ({b16.alu_out, b16.alu_out_hi, b16.carry} !== {16'h0002, 16'h0000, 1'b1}) begin
      fails++; $display("FAIL wide_shl got %h want %h", {b16.alu_out, b16.alu_out_hi, b16.carry}, {16'h0002, 16'h0000, 1'b1});
    end
    drain16();
  endtask

  initial begin
    b8.in_valid = 0; b8.out_ready = 0; b8.a = '0; b8.b = '0; b8.alu_sel = '0;
    b16.in_valid = 0; b16.out_ready = 0; b16.a = '0; b16.b = '0; b16.alu_sel = '0;
    test_reset();
    test_basic();
    test_flags();
    test_logic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
